alu_seq_ctrl: RTL

Multi-cycle sequencer that sits directly upstream of the 4-bit `alubranch` ALU. It fetches 16-bit instructions from an external instruction memory, reads two operands from a 4x4-bit register file, and drives `A`/`B`/`opcode` into the ALU. It consumes `result`/`zero` to write back a register or take a branch. Runs from `start` until a HALT instruction is executed.

---
 rtl/alu_seq_pkg.sv | 37 +++
 rtl/alu_seq_regfile.sv | 34 +++
 rtl/alu_seq_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared constants for the ALU sequencer.
// Opcodes, instruction field positions and FSM state encoding.
package alu_seq_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_BEQ = 3'b101;
   localparam logic [2:0] OP_BNE = 3'b110;
   localparam logic [2:0] OP_SYS = 3'b111;

   localparam int OP_HI    = 15;
   localparam int OP_LO    = 13;
   localparam int MODE_BIT = 12;
   localparam int F1_HI    = 11;
   localparam int F1_LO    = 10;
   localparam int F2_HI    = 9;
   localparam int F2_LO    = 8;
   localparam int F3_HI    = 7;
   localparam int F3_LO    = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_WB,
      ST_HALTED
   } state_t;

   function automatic logic is_branch(input logic [2:0] op);
      return (op == OP_BEQ) || (op == OP_BNE);
   endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: 4 x 4-bit register file.
// Two operand read ports, one debug read port, one write port.
module alu_seq_regfile
   import alu_seq_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_we,
   input  logic [1:0] i_wsel,
   input  logic [3:0] i_wdata,
   input  logic [1:0] i_ra_sel,
   input  logic [1:0] i_rb_sel,
   input  logic [1:0] i_dbg_sel,
   output logic [3:0] o_ra,
   output logic [3:0] o_rb,
   output logic [3:0] o_dbg
);

   logic [3:0] r_mem [4];

   // register storage, cleared by reset, written on i_we
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < 4; i++) r_mem[i] <= '0;
      end else if (i_we) begin
         r_mem[i_wsel] <= i_wdata;
      end
   end

   assign o_ra  = r_mem[i_ra_sel];
   assign o_rb  = r_mem[i_rb_sel];
   assign o_dbg = r_mem[i_dbg_sel];

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle fetch/decode/exec/writeback sequencer
// driving an external combinational ALU.
module alu_seq_ctrl
   import alu_seq_pkg::*;
#(
   parameter int PC_W = 4
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_start,
   output logic            o_imem_req,
   output logic [PC_W-1:0] o_imem_addr,
   input  logic            i_imem_valid,
   input  logic [15:0]     i_imem_data,
   output logic [3:0]      o_alu_a,
   output logic [3:0]      o_alu_b,
   output logic [2:0]      o_alu_op,
   input  logic [3:0]      i_alu_result,
   input  logic            i_alu_zero,
   output logic            o_busy,
   output logic            o_halted,
   input  logic [1:0]      i_dbg_sel,
   output logic [3:0]      o_dbg_data
);

   state_t          r_state;
   state_t          w_next;
   logic [PC_W-1:0] r_pc;
   logic [15:0]     r_ir;
   logic [3:0]      r_alu_a;
   logic [3:0]      r_alu_b;
   logic [2:0]      r_alu_op;
   logic [3:0]      r_res;
   logic            r_zero;

   logic [2:0]      w_op;
   logic            w_mode;
   logic [1:0]      w_f1;
   logic [1:0]      w_f2;
   logic [1:0]      w_f3;
   logic            w_is_alu;
   logic            w_is_br;
   logic            w_is_ldi;
   logic            w_is_halt;
   logic [1:0]      w_ra_sel;
   logic [1:0]      w_rb_sel;
   logic [3:0]      w_ra;
   logic [3:0]      w_rb;
   logic            w_we;
   logic [3:0]      w_wdata;
   logic [PC_W-1:0] w_pc_nxt;
   logic            w_unused;

   assign w_op      = r_ir[OP_HI:OP_LO];
   assign w_mode    = r_ir[MODE_BIT];
   assign w_f1      = r_ir[F1_HI:F1_LO];
   assign w_f2      = r_ir[F2_HI:F2_LO];
   assign w_f3      = r_ir[F3_HI:F3_LO];
   assign w_is_alu  = (w_op <= OP_XOR);
   assign w_is_br   = is_branch(w_op);
   assign w_is_ldi  = (w_op == OP_SYS) && !w_mode;
   assign w_is_halt = (w_op == OP_SYS) && w_mode;
   assign w_unused  = ^r_ir[5:4];

   // ALU ops read f2/f3; branches (and SYS) read f1/f2
   assign w_ra_sel = w_is_alu ? w_f2 : w_f1;
   assign w_rb_sel = w_is_alu ? w_f3 : w_f2;

   assign w_we    = (r_state == ST_WB) && (w_is_alu || w_is_ldi);
   assign w_wdata = w_is_ldi ? r_ir[3:0] : r_res;

   assign w_pc_nxt = (w_is_br && r_zero) ? r_ir[PC_W-1:0]
                                         : r_pc + PC_W'(1);

   alu_seq_regfile u_rf (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_we      (w_we),
      .i_wsel    (w_f1),
      .i_wdata   (w_wdata),
      .i_ra_sel  (w_ra_sel),
      .i_rb_sel  (w_rb_sel),
      .i_dbg_sel (i_dbg_sel),
      .o_ra      (w_ra),
      .o_rb      (w_rb),
      .o_dbg     (o_dbg_data)
   );

   // state register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   // next state and status outputs
   always_comb begin
      w_next     = r_state;
      o_imem_req = 1'b0;
      o_busy     = 1'b1;
      o_halted   = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            o_busy = 1'b0;
            if (i_start) w_next = ST_FETCH;
         end
         ST_HALTED: begin
            o_busy   = 1'b0;
            o_halted = 1'b1;
            if (i_start) w_next = ST_FETCH;
         end
         ST_FETCH: begin
            o_imem_req = 1'b1;
            if (i_imem_valid) w_next = ST_DECODE;
         end
         ST_DECODE: w_next = ST_EXEC;
         ST_EXEC:   w_next = ST_WB;
         ST_WB:     w_next = w_is_halt ? ST_HALTED : ST_FETCH;
         default:   w_next = ST_IDLE;
      endcase
   end

   // datapath registers: PC, IR, ALU drive and result latches
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pc     <= '0;
         r_ir     <= '0;
         r_alu_a  <= '0;
         r_alu_b  <= '0;
         r_alu_op <= '0;
         r_res    <= '0;
         r_zero   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_HALTED: begin
               if (i_start) r_pc <= '0;
            end
            ST_FETCH: begin
               if (i_imem_valid) r_ir <= i_imem_data;
            end
            ST_DECODE: begin
               r_alu_a  <= w_ra;
               r_alu_b  <= w_rb;
               r_alu_op <= w_op;
            end
            ST_EXEC: begin
               r_res  <= i_alu_result;
               r_zero <= i_alu_zero;
            end
            ST_WB: begin
               if (!w_is_halt) r_pc <= w_pc_nxt;
            end
            default: ;
         endcase
      end
   end

   assign o_imem_addr = r_pc;
   assign o_alu_a     = r_alu_a;
   assign o_alu_b     = r_alu_b;
   assign o_alu_op    = r_alu_op;

endmodule
